zbb_encoder: RTL and testbench
==============================

Name: zbb_encoder

Overview:
Streaming Zbb instruction encoder. It is the encode-side counterpart of the core's Zbb decode/execute unit. It accepts symbolic Zbb operation requests (op select plus register and shamt fields) over a valid/ready interface and assembles legal RV32 Zbb instruction words. Words are buffered in a small FIFO and emitted over a second valid/ready interface. It feeds the instruction-memory loader and the self-check program generator, so every Zbb encoding the core decodes can be produced by hardware.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2.
CNTW, 16, width of the emitted-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
in_op  in  5  operation select (encoding below).
in_rd  in  5  destination register index.
in_rs1  in  5  source register 1 index.
in_rs2  in  5  source register 2 index; ignored by unary and immediate ops.
in_shamt  in  5  rotate amount; used by RORI only.
out_valid  out  1  out_instr holds a valid word.
out_ready  in  1  consumer accepts the word.
out_instr  out  32  encoded instruction word.
level  out  $clog2(DEPTH+1)  current FIFO occupancy.
err_illegal  out  1  sticky flag: an illegal in_op was accepted.
err_clr  in  1  clears err_illegal.
issued_cnt  out  CNTW  count of words popped from the output.

Behaviour:
- in_op map:
  - 0 ANDN, 1 ORN, 2 XNOR, 3 CLZ, 4 CTZ, 5 CPOP
  - 6 MAX, 7 MAXU, 8 MIN, 9 MINU
  - 10 SEXTB, 11 SEXTH, 12 ZEXTH
  - 13 ROL, 14 ROR, 15 RORI, 16 ORCB, 17 REV8
  - 18–31 illegal.
- R-type ops, opcode 0110011: {f7, rs2, rs1, f3, rd, opcode}.
  - ANDN f7=0100000 f3=111; ORN 0100000/110; XNOR 0100000/100.
  - MAX 0000101/110; MAXU 0000101/111; MIN 0000101/100; MINU 0000101/101.
  - ROL 0110000/001; ROR 0110000/101.
  - ZEXTH f7=0000100 f3=100, rs2 field forced to 0.
- I-type ops, opcode 0010011: {imm12, rs1, f3, rd, opcode}.
  - CLZ 0x600/001; CTZ 0x601/001; CPOP 0x602/001.
  - SEXTB 0x604/001; SEXTH 0x605/001.
  - ORCB 0x287/101; REV8 0x698/101.
  - RORI imm={0110000, in_shamt}, f3=101.
- Accept occurs on in_valid && in_ready.
  - in_ready = (level != DEPTH). No bypass: when full, in_ready=0 even if a pop happens the same cycle.
  - Legal op: the encoded word is written into the FIFO at the accept edge and is visible on out_instr/out_valid the next cycle (latency 1 when empty).
  - Illegal op: the request is consumed and nothing is enqueued. err_illegal is set at the accept edge and stays set until err_clr.
  - err_clr and an illegal accept in the same cycle: set wins.
- Output side:
  - out_valid = (level != 0).
  - out_instr = head entry; it holds stable while out_valid && !out_ready.
  - Pop occurs on out_valid && out_ready.
- Simultaneous push and pop: level is unchanged; FIFO order is strictly preserved.
- Pointers wrap modulo DEPTH.
- issued_cnt increments on each pop and wraps from 2^CNTW−1 to 0.
- Reset, including mid-stream: FIFO is emptied; level=0, out_valid=0, in_ready=1, err_illegal=0, issued_cnt=0. out_instr is don't-care while out_valid=0.
- in_* inputs are sampled only at accept; values outside the accept cycle are ignored.

Test Plan:
1. After reset: ANDN rd=1 rs1=2 rs2=3, out_ready=1 → next cycle out_valid=1, out_instr=0x403170B3; issued_cnt=1 one cycle later.
2. CLZ rd=5 rs1=6, then RORI rd=1 rs1=1 shamt=31, then REV8 rd=10 rs1=11, then ZEXTH rd=2 rs1=3 rs2=7 → words in order 0x60031293, 0x61F0D093, 0x6985D513, 0x0801C133.
3. out_ready=0, push 5 requests with DEPTH=4 → in_ready drops after the 4th accept, level=4, 5th request held. Raise out_ready → 5th accepted only after the first pop; all 5 words emitted in order.
4. Full FIFO, in_valid=1, out_ready=1 in the same cycle → pop happens, no push that cycle, level=3; push lands on the next cycle.
5. in_op=20 accepted → level unchanged, err_illegal=1 and stays set. Assert err_clr → err_illegal=0. err_clr together with a new illegal accept → err_illegal stays 1.
6. Assert rst with 3 words queued → next cycle level=0, out_valid=0, issued_cnt=0. Then a subsequent CPOP rd=0 rs1=0 → 0x60201013.

Source files
------------

// File: rtl/zbb_encoder.sv
// zbb_encoder: streaming RV32 Zbb instruction encoder.
// Accepts symbolic Zbb requests (op select plus register/shamt fields) over a
// valid/ready input, assembles the 32-bit instruction word, buffers it in a
// DEPTH-entry FIFO and emits it over a valid/ready output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_op               operation select (0..17 legal, 18..31 illegal)
//   in_rd/in_rs1/in_rs2 register fields; in_shamt rotate amount for RORI
//   out_valid/out_ready output handshake; out_instr is the FIFO head word
//   level               FIFO occupancy
//   err_illegal/err_clr sticky illegal-op flag and its clear
//   issued_cnt          count of popped words (wraps)
module zbb_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [4:0]                 in_shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err_illegal,
  input  logic                       err_clr,
  output logic [CNTW-1:0]            issued_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpcR = 7'b0110011;
  localparam logic [6:0] OpcI = 7'b0010011;

  localparam logic [6:0] F7Neg = 7'b0100000;  // ANDN/ORN/XNOR
  localparam logic [6:0] F7Mm  = 7'b0000101;  // MAX/MIN family
  localparam logic [6:0] F7Rot = 7'b0110000;  // ROL/ROR/RORI
  localparam logic [6:0] F7Zxh = 7'b0000100;  // ZEXT.H

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [31:0] w_word;
  logic        w_legal;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OpcR};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OpcI};
  endfunction

  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (in_op)
      5'd0:  w_word = enc_r(F7Neg, in_rs2, in_rs1, 3'b111, in_rd);  // ANDN
      5'd1:  w_word = enc_r(F7Neg, in_rs2, in_rs1, 3'b110, in_rd);  // ORN
      5'd2:  w_word = enc_r(F7Neg, in_rs2, in_rs1, 3'b100, in_rd);  // XNOR
      5'd3:  w_word = enc_i(12'h600, in_rs1, 3'b001, in_rd);        // CLZ
      5'd4:  w_word = enc_i(12'h601, in_rs1, 3'b001, in_rd);        // CTZ
      5'd5:  w_word = enc_i(12'h602, in_rs1, 3'b001, in_rd);        // CPOP
      5'd6:  w_word = enc_r(F7Mm, in_rs2, in_rs1, 3'b110, in_rd);   // MAX
      5'd7:  w_word = enc_r(F7Mm, in_rs2, in_rs1, 3'b111, in_rd);   // MAXU
      5'd8:  w_word = enc_r(F7Mm, in_rs2, in_rs1, 3'b100, in_rd);   // MIN
      5'd9:  w_word = enc_r(F7Mm, in_rs2, in_rs1, 3'b101, in_rd);   // MINU
      5'd10: w_word = enc_i(12'h604, in_rs1, 3'b001, in_rd);        // SEXT.B
      5'd11: w_word = enc_i(12'h605, in_rs1, 3'b001, in_rd);        // SEXT.H
      // ZEXT.H is R-format with the rs2 field hard-wired to x0
      5'd12: w_word = enc_r(F7Zxh, 5'd0, in_rs1, 3'b100, in_rd);
      5'd13: w_word = enc_r(F7Rot, in_rs2, in_rs1, 3'b001, in_rd);  // ROL
      5'd14: w_word = enc_r(F7Rot, in_rs2, in_rs1, 3'b101, in_rd);  // ROR
      5'd15: w_word = enc_i({F7Rot, in_shamt}, in_rs1, 3'b101, in_rd);  // RORI
      5'd16: w_word = enc_i(12'h287, in_rs1, 3'b101, in_rd);        // ORC.B
      5'd17: w_word = enc_i(12'h698, in_rs1, 3'b101, in_rd);        // REV8
      default: w_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_err;
  logic [CNTW-1:0] r_cnt;

  logic w_accept;
  logic w_push;
  logic w_pop;

  // No full-side bypass: a pop in the same cycle does not open the input.
  assign in_ready  = (r_level != LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign out_instr = r_mem[r_rd_ptr];

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_cnt    <= r_cnt + CNTW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      // Setting takes priority over a simultaneous clear.
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign level       = r_level;
  assign err_illegal = r_err;
  assign issued_cnt  = r_cnt;

endmodule

// File: tb/tb_zbb_encoder.sv
// Self-checking bench for zbb_encoder: table of per-op encodings plus
// hand-written handshake, back-pressure, error-flag and reset sequences.
module tb_zbb_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 4;  // small so the counter wrap is reached
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op, in_rd, in_rs1, in_rs2, in_shamt;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [LW-1:0]   level;
  logic            err_illegal;
  logic            err_clr;
  logic [CNTW-1:0] issued_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  zbb_encoder #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_shamt    (in_shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .level       (level),
    .err_illegal (err_illegal),
    .err_clr     (err_clr),
    .issued_cnt  (issued_cnt)
  );

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic push(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] shamt);
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_shamt = shamt;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] word);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_instr"}, out_instr, word);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNTW);
  endtask

  initial begin
    vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0, 32'h403170B3};  // ANDN
    vecs[1]  = '{5'd1,  5'd1,  5'd2,  5'd3,  5'd0, 32'h403160B3};  // ORN
    vecs[2]  = '{5'd2,  5'd1,  5'd2,  5'd3,  5'd0, 32'h403140B3};  // XNOR
    vecs[3]  = '{5'd3,  5'd1,  5'd2,  5'd3,  5'd0, 32'h60011093};  // CLZ
    vecs[4]  = '{5'd4,  5'd1,  5'd2,  5'd3,  5'd0, 32'h60111093};  // CTZ
    vecs[5]  = '{5'd5,  5'd1,  5'd2,  5'd3,  5'd0, 32'h60211093};  // CPOP
    vecs[6]  = '{5'd6,  5'd1,  5'd2,  5'd3,  5'd0, 32'h0A3160B3};  // MAX
    vecs[7]  = '{5'd7,  5'd1,  5'd2,  5'd3,  5'd0, 32'h0A3170B3};  // MAXU
    vecs[8]  = '{5'd8,  5'd1,  5'd2,  5'd3,  5'd0, 32'h0A3140B3};  // MIN
    vecs[9]  = '{5'd9,  5'd1,  5'd2,  5'd3,  5'd0, 32'h0A3150B3};  // MINU
    vecs[10] = '{5'd10, 5'd1,  5'd2,  5'd3,  5'd0, 32'h60411093};  // SEXT.B
    vecs[11] = '{5'd11, 5'd1,  5'd2,  5'd3,  5'd0, 32'h60511093};  // SEXT.H
    vecs[12] = '{5'd12, 5'd1,  5'd2,  5'd3,  5'd0, 32'h080140B3};  // ZEXT.H, rs2 dropped
    vecs[13] = '{5'd13, 5'd1,  5'd2,  5'd3,  5'd0, 32'h603110B3};  // ROL
    vecs[14] = '{5'd14, 5'd1,  5'd2,  5'd3,  5'd0, 32'h603150B3};  // ROR
    vecs[15] = '{5'd15, 5'd1,  5'd2,  5'd3,  5'd5, 32'h60515093};  // RORI 5
    vecs[16] = '{5'd16, 5'd1,  5'd2,  5'd3,  5'd0, 32'h28715093};  // ORC.B
    vecs[17] = '{5'd17, 5'd1,  5'd2,  5'd3,  5'd0, 32'h69815093};  // REV8
    vecs[18] = '{5'd0,  5'd31, 5'd31, 5'd31, 5'd0, 32'h41FFFFB3};  // ANDN all-ones fields
    vecs[19] = '{5'd5,  5'd0,  5'd0,  5'd9,  5'd7, 32'h60201013};  // CPOP ignores rs2/shamt

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_shamt = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_cnt", 32'(issued_cnt), 32'd0);

    // Test 1: ANDN with out_ready held high, latency 1
    out_ready = 1'b1;
    push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_instr", out_instr, 32'h403170B3);
    step();
    exp_cnt = 1;
    chk("t1_cnt", 32'(issued_cnt), 32'd1);
    chk("t1_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Test 2: mixed formats, order preserved
    push(5'd3, 5'd5, 5'd6, 5'd0, 5'd0);
    push(5'd15, 5'd1, 5'd1, 5'd0, 5'd31);
    push(5'd17, 5'd10, 5'd11, 5'd0, 5'd0);
    push(5'd12, 5'd2, 5'd3, 5'd7, 5'd0);
    chk("t2_level", 32'(level), 32'd4);
    pop_check("t2_w0", 32'h60031293);
    pop_check("t2_w1", 32'h61F0D093);
    pop_check("t2_w2", 32'h6985D513);
    pop_check("t2_w3", 32'h0801C133);
    chk("t2_cnt", 32'(issued_cnt), 32'(exp_cnt));

    // Table: every op, one push/pop each; also walks issued_cnt through its wrap
    for (int i = 0; i < 20; i++) begin
      push(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].shamt);
      pop_check($sformatf("vec%0d", i), vecs[i].word);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'd0);
      chk($sformatf("vec%0d_cnt", i), 32'(issued_cnt), 32'(exp_cnt));
    end
    chk("table_no_err", {31'd0, err_illegal}, 32'd0);

    // Tests 3/4: back-pressure, full FIFO, no bypass on simultaneous pop
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].shamt);
    end
    chk("t3_full_level", 32'(level), 32'd4);
    chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
    in_op = vecs[4].op; in_rd = vecs[4].rd; in_rs1 = vecs[4].rs1;
    in_rs2 = vecs[4].rs2; in_shamt = vecs[4].shamt;
    in_valid = 1'b1;
    step(); step();
    chk("t3_held_level", 32'(level), 32'd4);
    chk("t3_head_stable", out_instr, vecs[0].word);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNTW);
    chk("t4_pop_no_push", 32'(level), 32'd3);
    chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_push_next", 32'(level), 32'd4);
    for (int i = 1; i < 5; i++) begin
      pop_check($sformatf("t3_w%0d", i), vecs[i].word);
    end
    chk("t3_drained", 32'(level), 32'd0);
    chk("t3_cnt", 32'(issued_cnt), 32'(exp_cnt));

    // Test 5: illegal ops and the sticky flag
    push(5'd20, 5'd1, 5'd2, 5'd3, 5'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_err_set", {31'd0, err_illegal}, 32'd1);
    step();
    chk("t5_err_sticky", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_err_clr", {31'd0, err_illegal}, 32'd0);
    push(5'd18, 5'd1, 5'd2, 5'd3, 5'd0);
    chk("t5_op18", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    step();
    chk("t5_err_clr2", {31'd0, err_illegal}, 32'd0);
    push(5'd31, 5'd1, 5'd2, 5'd3, 5'd0);  // err_clr still high: set wins
    err_clr = 1'b0;
    chk("t5_set_wins", {31'd0, err_illegal}, 32'd1);
    chk("t5_level2", 32'(level), 32'd0);

    // Test 6: mid-stream reset
    for (int i = 0; i < 3; i++) begin
      push(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].shamt);
    end
    chk("t6_pre_level", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_cnt", 32'(issued_cnt), 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_err", {31'd0, err_illegal}, 32'd0);
    push(5'd5, 5'd0, 5'd0, 5'd0, 5'd0);
    pop_check("t6_cpop", 32'h60201013);
    chk("t6_cnt_after", 32'(issued_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
